// File: rtl/usb_serial_uart_phy.sv
// UART bridge between the usb_serial_core byte pipes and real TX/RX pins (8N1 by default).
// Define USB_SERIAL_UART_PARITY_EN to add an even-parity bit after bit 7 in both directions.
module usb_serial_uart_phy #(
  parameter int CLKS_PER_BIT = 416
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] uart_out_data,
  input  logic       uart_out_valid,
  output logic       uart_out_get,
  output logic [7:0] uart_in_data,
  output logic       uart_in_valid,
  input  logic       uart_in_ready,
  output logic       uart_tx,
  input  logic       uart_rx,
  output logic       tx_busy,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_parity_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA,
`ifdef USB_SERIAL_UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA,
`ifdef USB_SERIAL_UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

  tx_state_t      tx_state;
  logic [CW-1:0]  tx_cnt;
  logic [2:0]     tx_bit;
  logic [7:0]     tx_shift;
  logic           tx_par;

  rx_state_t      rx_state;
  logic [CW-1:0]  rx_cnt;
  logic [2:0]     rx_bit;
  logic [7:0]     rx_shift;
  logic [1:0]     rx_sync;
  logic           rx_s;
  logic           rx_armed;
  logic           rx_par_bad;

  assign rx_s    = rx_sync[1];
  assign tx_busy = (tx_state != TX_IDLE);

  // The get cycle is also the first cycle of the start bit, so the frame is exactly N bit times long.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state     <= TX_IDLE;
      uart_tx      <= 1'b1;
      uart_out_get <= 1'b0;
      tx_cnt       <= '0;
      tx_bit       <= '0;
      tx_shift     <= '0;
      tx_par       <= 1'b0;
    end else begin
      uart_out_get <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (uart_out_valid) begin
            uart_out_get <= 1'b1;
            uart_tx      <= 1'b0;
            tx_shift     <= uart_out_data;
            tx_par       <= ^uart_out_data;
            tx_cnt       <= '0;
            tx_state     <= TX_START;
          end
        end
        default: begin
          if (tx_cnt != BIT_LAST) begin
            tx_cnt <= tx_cnt + 1'b1;
          end else begin
            tx_cnt <= '0;
            case (tx_state)
              TX_START: begin
                uart_tx  <= tx_shift[0];
                tx_shift <= tx_shift >> 1;
                tx_bit   <= '0;
                tx_state <= TX_DATA;
              end
              TX_DATA: begin
                if (tx_bit != 3'd7) begin
                  uart_tx  <= tx_shift[0];
                  tx_shift <= tx_shift >> 1;
                  tx_bit   <= tx_bit + 1'b1;
                end else begin
`ifdef USB_SERIAL_UART_PARITY_EN
                  uart_tx  <= tx_par;
                  tx_state <= TX_PARITY;
`else
                  uart_tx  <= 1'b1;
                  tx_state <= TX_STOP;
`endif
                end
              end
`ifdef USB_SERIAL_UART_PARITY_EN
              TX_PARITY: begin
                uart_tx  <= 1'b1;
                tx_state <= TX_STOP;
              end
`endif
              default: tx_state <= TX_IDLE;
            endcase
          end
        end
      endcase
    end
  end

  // After a framing error the line may sit low (break); rx_armed blocks a false start until it idles high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_sync       <= 2'b11;
      rx_state      <= RX_IDLE;
      rx_cnt        <= '0;
      rx_bit        <= '0;
      rx_shift      <= '0;
      rx_armed      <= 1'b1;
      uart_in_data  <= '0;
      uart_in_valid <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
`ifdef USB_SERIAL_UART_PARITY_EN
      rx_par_bad    <= 1'b0;
      rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_sync      <= {rx_sync[0], uart_rx};
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
`ifdef USB_SERIAL_UART_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
      if (uart_in_valid && uart_in_ready) uart_in_valid <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_s) rx_armed <= 1'b1;
          if (rx_armed && !rx_s) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt != HALF_LAST) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_state <= rx_s ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_cnt != BIT_LAST) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 1'b1;
`ifdef USB_SERIAL_UART_PARITY_EN
            if (rx_bit == 3'd7) rx_state <= RX_PARITY;
`else
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
`endif
          end
        end
`ifdef USB_SERIAL_UART_PARITY_EN
        RX_PARITY: begin
          if (rx_cnt != BIT_LAST) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt        <= '0;
            rx_par_bad    <= rx_s ^ (^rx_shift);
            rx_parity_err <= rx_s ^ (^rx_shift);
            rx_state      <= RX_STOP;
          end
        end
`endif
        default: begin
          if (rx_cnt != BIT_LAST) begin
            rx_cnt <= rx_cnt + 1'b1;
          end else begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (!rx_s) begin
              rx_frame_err <= 1'b1;
              rx_armed     <= 1'b0;
            end else if (!rx_par_bad) begin
              if (!uart_in_valid || uart_in_ready) begin
                uart_in_data  <= rx_shift;
                uart_in_valid <= 1'b1;
              end else begin
                rx_overrun <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

`ifndef USB_SERIAL_UART_PARITY_EN
  assign rx_par_bad    = 1'b0;
  assign rx_parity_err = 1'b0;
`endif

endmodule
